// File: rtl/assoc_icache.sv
// N-way set-associative instruction cache with multi-word blocks and round-robin replacement.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module assoc_icache #(
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int WORDS  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] imemload,
    input  logic              flush,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [DATA_W-1:0] iload
`ifdef ICACHE_STATS_EN
   ,output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    // state | meaning
    // IDLE  | serve hits, start a refill on a miss
    // FILL  | fetch block words from memory into the victim way
    localparam int WO_B  = $clog2(WORDS);
    localparam int IX_B  = $clog2(SETS);
    localparam int TAG_B = ADDR_W - 2 - WO_B - IX_B;
    localparam int CW    = (WORDS > 1) ? WO_B : 1;
    localparam int PW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state_q, state_d;

    logic              valid_q [SETS][WAYS];
    logic [TAG_B-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];
    logic [PW-1:0]     ptr_q   [SETS];

    logic [ADDR_W-1:0] base_q;
    logic [PW-1:0]     vic_q;
    logic              via_ptr_q;
    logic [CW-1:0]     cnt_q;

    logic [IX_B-1:0]   req_idx, fill_idx;
    logic [TAG_B-1:0]  req_tag, fill_tag;
    logic [CW-1:0]     req_word;
    logic              hit_any, inv_any;
    logic [PW-1:0]     hit_way, inv_way;
    logic              start_fill, fill_done;
    logic              unused_bits;

    assign req_idx     = imemaddr[2+WO_B +: IX_B];
    assign req_tag     = imemaddr[ADDR_W-1 -: TAG_B];
    assign fill_idx    = base_q[2+WO_B +: IX_B];
    assign fill_tag    = base_q[ADDR_W-1 -: TAG_B];
    assign unused_bits = ^imemaddr[1:0];

    generate
        if (WORDS > 1) begin : g_word
            assign req_word = imemaddr[2 +: CW];
        end else begin : g_noword
            assign req_word = '0;
        end
    endgenerate

    // Descending scan leaves the lowest-indexed invalid way selected.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = PW'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_any = 1'b1;
                inv_way = PW'(w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN && !flush) begin
                    if (hit_any) begin
                        ihit     = 1'b1;
                        imemload = data_q[req_idx][hit_way][req_word];
                    end else begin
                        start_fill = 1'b1;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = base_q + (ADDR_W'(cnt_q) << 2);
                if (flush) begin
                    state_d = IDLE;
                end else if (!iwait && cnt_q == CW'(WORDS - 1)) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            base_q    <= '0;
            vic_q     <= '0;
            via_ptr_q <= 1'b0;
            cnt_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    ptr_q[s] <= '0;
                    for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
                end
            end
            if (start_fill) begin
                base_q    <= {imemaddr[ADDR_W-1:2+WO_B], {(2+WO_B){1'b0}}};
                vic_q     <= inv_any ? inv_way : ptr_q[req_idx];
                via_ptr_q <= !inv_any;
                cnt_q     <= '0;
            end else if (state_q == FILL && !iwait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fill_done) begin
                valid_q[fill_idx][vic_q] <= 1'b1;
                tag_q[fill_idx][vic_q]   <= fill_tag;
                if (via_ptr_q && WAYS > 1) ptr_q[fill_idx] <= ptr_q[fill_idx] + 1'b1;
            end
        end
    end

    // Words of an aborted fill may land here; the line simply stays invalid.
    always_ff @(posedge CLK) begin
        if (state_q == FILL && !iwait) data_q[fill_idx][vic_q][cnt_q] <= iload;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) hit_count <= hit_count + 32'd1;
            if (start_fill) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_icache.sv
// Scoreboard bench for assoc_icache: block-level reference model, memory responder, decoupled monitor.
module tb_assoc_icache;
    localparam int SETS = 8, WAYS = 2, WORDS = 2, ADDR_W = 32, DATA_W = 32;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              imemREN = 1'b0;
    logic [ADDR_W-1:0] imemaddr = '0;
    logic              ihit;
    logic [DATA_W-1:0] imemload;
    logic              flush = 1'b0;
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait = 1'b1;
    logic [DATA_W-1:0] iload = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count, miss_count;
`endif

    assoc_icache #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
        .imemload(imemload), .flush(flush), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload)
`ifdef ICACHE_STATS_EN
       ,.hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: each set holds WAYS block numbers plus a round-robin pointer.
    typedef struct {
        logic [31:0] data;
        int          xfers;
    } exp_t;

    bit          mv   [SETS][WAYS];
    int unsigned mblk [SETS][WAYS];
    int          mp   [SETS];
    int          exp_hits = 0;
    int          exp_miss = 0;
    exp_t        eq[$];
    logic [31:0] xq[$];

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++) begin
            mp[s] = 0;
            for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
        end
    endfunction

    function automatic void model_req(logic [31:0] a, bit do_entry, int extra);
        int unsigned blk = a / (4 * WORDS);
        int s = int'(blk % SETS);
        int v = -1;
        bit hit = 1'b0;
        for (int w = 0; w < WAYS; w++) if (mv[s][w] && mblk[s][w] == blk) hit = 1'b1;
        if (!hit) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
            if (v < 0) begin
                v = mp[s];
                mp[s] = (mp[s] + 1) % WAYS;
            end
            mv[s][v] = 1'b1;
            mblk[s][v] = blk;
            for (int k = 0; k < WORDS; k++) xq.push_back(32'(blk * 4 * WORDS + 4 * k));
            exp_miss++;
        end
        if (do_entry) begin
            eq.push_back('{mem_word(a), (hit ? 0 : WORDS) + extra});
            exp_hits++;
        end
    endfunction

    // Memory responder: 0 random wait, 1 no wait, 2 two wait cycles per word.
    int wmode = 0;
    int wcnt = 0;
    always @(posedge CLK) begin
        #2;
        iload = mem_word(iaddr);
        if (!iREN) begin
            iwait = 1'($urandom_range(0, 1));
            wcnt = 0;
        end else begin
            case (wmode)
                0: iwait = 1'($urandom_range(0, 1));
                1: iwait = 1'b0;
                default: begin
                    if (wcnt < 2) begin
                        iwait = 1'b1;
                        wcnt++;
                    end else begin
                        iwait = 1'b0;
                        wcnt = 0;
                    end
                end
            endcase
        end
    end

    int cyc = 0, last_xfer = -10, xfers_since = 0, req_cyc = 0;
    always @(negedge CLK) begin
        if (nRST) begin
            exp_t e;
            cyc++;
            if (imemREN) req_cyc++;
            if (iREN && !iwait) begin
                if (xq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL xfer_unexpected: got addr %h expected none", iaddr);
                end else begin
                    check("xfer_addr", iaddr, xq.pop_front());
                end
                xfers_since++;
                last_xfer = cyc;
            end
            if (ihit) begin
                if (eq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL hit_unexpected: got ihit for %h expected none", imemaddr);
                end else begin
                    e = eq.pop_front();
                    check("imemload", imemload, e.data);
                    check("xfer_count", 32'(xfers_since), 32'(e.xfers));
                    if (e.xfers > 0) check("miss_latency", 32'(cyc - last_xfer), 32'd1);
                    else check("hit_latency", 32'(req_cyc), 32'd1);
                end
                xfers_since = 0;
                req_cyc = 0;
            end
        end
    end

    task automatic finish_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic wait_hit();
        int n = 0;
        @(negedge CLK);
        while (!ihit && n < 300) begin
            n++;
            @(negedge CLK);
        end
        if (!ihit) begin
            total++;
            bad++;
            $display("FAIL hit_timeout: got no ihit expected ihit for %h", imemaddr);
            finish_test();
        end
    endtask

    task automatic fetch(logic [31:0] a);
        @(posedge CLK) #1;
        imemREN = 1'b1;
        imemaddr = a;
        model_req(a, 1'b1, 0);
        wait_hit();
    endtask

    task automatic idle();
        @(posedge CLK) #1;
        imemREN = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge CLK) #1;
        imemREN = 1'b0;
        flush = 1'b1;
        model_flush();
        @(posedge CLK) #1;
        flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_flush();
        imemREN = 1'b1;
        imemaddr = 32'h40;
        #12;
        check("rst_ihit", 32'(ihit), 0);
        check("rst_iren", 32'(iREN), 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_imemload", imemload, 0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
`endif
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        // cold miss with slow memory, then hit on the other word
        wmode = 2;
        fetch(32'h40);
        fetch(32'h44);
        idle();
`ifdef ICACHE_STATS_EN
        @(negedge CLK);
        check("stats_hits", hit_count, 32'(exp_hits));
        check("stats_misses", miss_count, 32'(exp_miss));
`endif

        // conflict eviction in set 0
        do_flush();
        wmode = 0;
        fetch(32'h000);
        fetch(32'h040);
        fetch(32'h080);
        fetch(32'h000);
        fetch(32'h040);
        idle();

        // flush after the first word of a fill
        do_flush();
        wmode = 1;
        @(posedge CLK) #1;
        imemREN = 1'b1;
        imemaddr = 32'h300;
        xq.push_back(32'h300);
        xq.push_back(32'h304);
        exp_miss++;
        @(posedge CLK);
        @(posedge CLK) #1;
        flush = 1'b1;
        model_flush();
        model_req(32'h300, 1'b1, 2);
        @(posedge CLK) #1;
        flush = 1'b0;
        @(negedge CLK);
        check("iren_after_flush", 32'(iREN), 0);
        wait_hit();
        idle();

        // warm four lines, flush, all refetches miss, pointer restarts
        wmode = 0;
        fetch(32'h000);
        fetch(32'h040);
        fetch(32'h008);
        fetch(32'h048);
        do_flush();
        fetch(32'h000);
        fetch(32'h040);
        fetch(32'h008);
        fetch(32'h048);
        fetch(32'h080);
        fetch(32'h040);
        fetch(32'h000);
        // flush beats a hit in the same cycle
        @(posedge CLK) #1;
        imemREN = 1'b1;
        imemaddr = 32'h040;
        flush = 1'b1;
        model_flush();
        model_req(32'h040, 1'b1, 0);
        @(negedge CLK);
        check("ihit_during_flush", 32'(ihit), 0);
        @(posedge CLK) #1;
        flush = 1'b0;
        wait_hit();
        idle();

        // address changes while a fill is in flight
        do_flush();
        wmode = 1;
        @(posedge CLK) #1;
        imemREN = 1'b1;
        imemaddr = 32'h200;
        model_req(32'h200, 1'b0, 0);
        @(posedge CLK);
        @(posedge CLK) #1;
        imemaddr = 32'h100;
        model_req(32'h100, 1'b1, WORDS);
        wait_hit();
        fetch(32'h204);
        fetch(32'h104);
        idle();

        // random traffic
        wmode = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 3) | ($urandom_range(0, 1) << 2);
            if ($urandom_range(0, 24) == 0) do_flush();
            else if ($urandom_range(0, 6) == 0) idle();
            fetch(a);
        end
        idle();

`ifdef ICACHE_STATS_EN
        @(negedge CLK);
        check("stats_hits_total", hit_count, 32'(exp_hits));
        check("stats_misses_total", miss_count, 32'(exp_miss));
        fetch(32'h040);
        idle();
        @(posedge CLK) #1;
        force dut.hit_count = 32'hFFFF_FFFF;
        @(posedge CLK) #1;
        release dut.hit_count;
        fetch(32'h040);
        idle();
        @(negedge CLK);
        check("hit_count_wrap", hit_count, 32'h0);
`endif

        repeat (3) @(posedge CLK);
        #1;
        check("exp_queue_empty", 32'(eq.size()), 0);
        check("xfer_queue_empty", 32'(xq.size()), 0);
        finish_test();
    end
endmodule
